// File: rtl/axi_slave_mem_pkg.sv
// Shared types and the per-beat error rule for the AXI3 memory slave.
package axi_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_t;

  // A beat fails if it is wider than the bus, falls outside memory, or is
  // part of a WRAP burst whose length is not a power of two.
  function automatic logic beat_err(input logic [2:0] size,
                                    input logic [2:0] max_size,
                                    input logic       addr_ok,
                                    input logic [3:0] len,
                                    input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BURST_WRAP) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15});
    return (size > max_size) || !addr_ok || bad_wrap;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_burst_addr_gen
  import axi_slave_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ONE << size_i;
    incr      = addr_i + step;
    // Boundary minus one; only meaningful when LEN+1 is a power of two.
    wrap_mask = ((ADDR_WIDTH'(len_i) + ONE) << size_i) - ONE;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/mgc_axi_slave_mem.sv
// AXI3 memory-backed slave: one write and one read burst in flight,
// byte-strobed word array, registered R data and B response.
module mgc_axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [3:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic                    WVALID,
  output logic                    WREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic [1:0]              BRESP,
  output logic [ID_WIDTH-1:0]     BID,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [3:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic [ID_WIDTH-1:0]     ARID,
  output logic                    RVALID,
  input  logic                    RREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic [ID_WIDTH-1:0]     RID,
  output logic                    RLAST
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(NBYTES);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] MAX_SIZE = 3'(OFF);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(DEPTH) * (ADDR_WIDTH+1)'(NBYTES);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < MEM_BYTES;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[OFF +: IDX_W];
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  wstate_t               wstate_q;
  logic                  awready_q, wready_q, bvalid_q, werr_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [3:0]            wlen_q, wcnt_q;
  logic [2:0]            wsize_q;
  logic [1:0]            wburst_q;
  logic                  w_beat_err, w_last_beat, w_beat_bad, w_wen;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr_i      (waddr_q),
    .len_i       (wlen_q),
    .size_i      (wsize_q),
    .burst_i     (wburst_q),
    .next_addr_o (waddr_d)
  );

  assign w_beat_err  = beat_err(wsize_q, MAX_SIZE, in_range(waddr_q), wlen_q, wburst_q);
  assign w_last_beat = (wcnt_q == wlen_q);
  assign w_beat_bad  = w_beat_err || (WLAST != w_last_beat);
  assign w_wen       = wready_q && WVALID && !w_beat_err && !ARESET;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (AWVALID) begin
          waddr_q   <= AWADDR;
          wlen_q    <= AWLEN;
          wsize_q   <= AWSIZE;
          wburst_q  <= AWBURST;
          bid_q     <= AWID;
          wcnt_q    <= '0;
          werr_q    <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wstate_q  <= W_DATA;
        end
        // Burst length follows AWLEN; a misplaced WLAST only taints BRESP.
        W_DATA: if (WVALID) begin
          waddr_q <= waddr_d;
          wcnt_q  <= wcnt_q + 4'd1;
          werr_q  <= werr_q | w_beat_bad;
          if (w_last_beat) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= (werr_q | w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
            wstate_q <= W_RESP;
          end
        end
        W_RESP: if (BREADY) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          wstate_q  <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_wen) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (WSTRB[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  rstate_t               rstate_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q, r_word;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, rsel_addr;
  logic [3:0]            rlen_q, rcnt_q, rsel_len;
  logic [2:0]            rsize_q, rsel_size;
  logic [1:0]            rburst_q, rsel_burst;
  logic                  r_beat_err;

  // Idle loads beat 0 straight from AR; otherwise raddr_q holds the next beat.
  always_comb begin
    if (rstate_q == R_IDLE) begin
      rsel_addr  = ARADDR;
      rsel_len   = ARLEN;
      rsel_size  = ARSIZE;
      rsel_burst = ARBURST;
    end else begin
      rsel_addr  = raddr_q;
      rsel_len   = rlen_q;
      rsel_size  = rsize_q;
      rsel_burst = rburst_q;
    end
  end

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr_i      (rsel_addr),
    .len_i       (rsel_len),
    .size_i      (rsel_size),
    .burst_i     (rsel_burst),
    .next_addr_o (raddr_d)
  );

  assign r_beat_err = beat_err(rsel_size, MAX_SIZE, in_range(rsel_addr), rsel_len, rsel_burst);
  assign r_word     = mem_q[word_idx(rsel_addr)];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (ARVALID) begin
          rlen_q    <= ARLEN;
          rsize_q   <= ARSIZE;
          rburst_q  <= ARBURST;
          rid_q     <= ARID;
          raddr_q   <= raddr_d;
          rcnt_q    <= '0;
          rdata_q   <= r_beat_err ? '0 : r_word;
          rresp_q   <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
          rlast_q   <= (ARLEN == 4'd0);
          rvalid_q  <= 1'b1;
          arready_q <= 1'b0;
          rstate_q  <= R_DATA;
        end
        R_DATA: if (RREADY) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rstate_q  <= R_IDLE;
          end else begin
            raddr_q <= raddr_d;
            rcnt_q  <= rcnt_q + 4'd1;
            rdata_q <= r_beat_err ? '0 : r_word;
            rresp_q <= r_beat_err ? RESP_SLVERR : RESP_OKAY;
            rlast_q <= ((rcnt_q + 4'd1) == rlen_q);
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = bid_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;
  assign RID     = rid_q;
  assign RLAST   = rlast_q;

endmodule

// File: tb/tb_mgc_axi_slave_mem.sv
// Randomized bench for mgc_axi_slave_mem against a byte-level burst model.
`timescale 1ns/1ps
module tb_mgc_axi_slave_mem;
  localparam int DEPTH = 1024;
  localparam int MEMB  = DEPTH * 4;

  logic        ACLK = 1'b0, ARESET = 1'b1;
  logic        AWVALID = 0, AWREADY;
  logic [31:0] AWADDR = 0;
  logic [3:0]  AWLEN = 0;
  logic [2:0]  AWSIZE = 0;
  logic [1:0]  AWBURST = 0;
  logic [3:0]  AWID = 0;
  logic        WVALID = 0, WREADY;
  logic [31:0] WDATA = 0;
  logic [3:0]  WSTRB = 0;
  logic        WLAST = 0;
  logic        BVALID, BREADY = 0;
  logic [1:0]  BRESP;
  logic [3:0]  BID;
  logic        ARVALID = 0, ARREADY;
  logic [31:0] ARADDR = 0;
  logic [3:0]  ARLEN = 0;
  logic [2:0]  ARSIZE = 0;
  logic [1:0]  ARBURST = 0;
  logic [3:0]  ARID = 0;
  logic        RVALID, RREADY = 0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic [3:0]  RID;
  logic        RLAST;

  always #5 ACLK = ~ACLK;

  mgc_axi_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
    .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RID(RID), .RLAST(RLAST)
  );

  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rbeat_t;
  typedef struct packed {logic [1:0] resp; logic [3:0] id;} bexp_t;

  int tests = 0, fails = 0;
  logic [31:0] mw [DEPTH];
  rbeat_t rexp_q[$];
  bexp_t  bexp_q[$];
  logic [31:0] got_r[$];
  logic [1:0]  got_rr[$];
  logic [5:0]  got_b[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  bit chk_en = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned beat_addr(int unsigned a0, int len, int size, int burst, int i);
    int unsigned sz, bound, base;
    sz = 1 << size;
    if (burst == 0) return a0;
    if (burst == 2) begin
      bound = (len + 1) * sz;
      base  = a0 - (a0 % bound);
      return base + ((a0 - base) + i * sz) % bound;
    end
    return a0 + i * sz;
  endfunction

  function automatic bit beat_bad(int unsigned a, int len, int size, int burst);
    return (size > 2) || (a >= MEMB) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  // Per-cycle compare of the response channels against the expectation queues.
  rbeat_t e_r;
  bexp_t  e_b;
  logic pv_rv = 0, pv_rr = 0, pv_rst = 1;
  logic [38:0] pv_r = '0;
  always @(negedge ACLK) begin
    if (chk_en) begin
      if (pv_rv && !pv_rr && !pv_rst)
        check("r_hold", {RVALID, RDATA, RRESP, RLAST, RID}, {1'b1, pv_r});
      if (RVALID && RREADY) begin
        if (rexp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL r_extra: unexpected R beat data %h", RDATA);
        end else begin
          e_r = rexp_q.pop_front();
          check("r_beat", {RDATA, RRESP, RLAST, RID}, e_r);
          got_r.push_back(RDATA);
          got_rr.push_back(RRESP);
        end
      end
      if (BVALID && BREADY) begin
        if (bexp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL b_extra: unexpected B resp %b id %h", BRESP, BID);
        end else begin
          e_b = bexp_q.pop_front();
          check("b_resp", {BRESP, BID}, e_b);
          got_b.push_back({BRESP, BID});
        end
      end
    end
    pv_rv  = RVALID;
    pv_rr  = RREADY;
    pv_rst = ARESET;
    pv_r   = {RDATA, RRESP, RLAST, RID};
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input int unsigned a, input int len, input int size, input int burst,
                          input logic [3:0] id, input int bad, input bit stall);
    bit err;
    int unsigned ba;
    int cyc;
    err = 0;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, len, size, burst, i);
      if (beat_bad(ba, len, size, burst)) err = 1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) mw[ba >> 2][8*b +: 8] = wd[i][8*b +: 8];
      if (i == bad) err = 1;
    end
    bexp_q.push_back({err ? 2'b10 : 2'b00, id});
    AWVALID = 1; AWADDR = a; AWLEN = 4'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWID = id;
    cyc = 0;
    while (!AWREADY && cyc < 50) begin tick(); cyc++; end
    tick();
    AWVALID = 0;
    for (int i = 0; i <= len; i++) begin
      if (stall && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) tick();
      WVALID = 1; WDATA = wd[i]; WSTRB = ws[i]; WLAST = (i == len) ^ (i == bad);
      cyc = 0;
      while (!WREADY && cyc < 50) begin tick(); cyc++; end
      tick();
      WVALID = 0; WLAST = 0;
    end
    if (stall) repeat ($urandom_range(0, 2)) tick();
    BREADY = 1;
    cyc = 0;
    while (!BVALID && cyc < 50) begin tick(); cyc++; end
    check("b_arrive", BVALID, 1'b1);
    tick();
    BREADY = 0;
  endtask

  task automatic push_r(input int unsigned a, input int len, input int size, input int burst, input logic [3:0] id);
    int unsigned ba;
    bit bad;
    for (int i = 0; i <= len; i++) begin
      ba  = beat_addr(a, len, size, burst, i);
      bad = beat_bad(ba, len, size, burst);
      rexp_q.push_back({bad ? 32'h0 : mw[ba >> 2], bad ? 2'b10 : 2'b00, (i == len), id});
    end
  endtask

  task automatic send_ar(input int unsigned a, input int len, input int size, input int burst, input logic [3:0] id);
    int cyc;
    ARVALID = 1; ARADDR = a; ARLEN = 4'(len); ARSIZE = 3'(size); ARBURST = 2'(burst); ARID = id;
    cyc = 0;
    while (!ARREADY && cyc < 50) begin tick(); cyc++; end
    tick();
    ARVALID = 0;
  endtask

  task automatic do_read(input int unsigned a, input int len, input int size, input int burst,
                         input logic [3:0] id, input bit stall, input int hold_beat);
    int n, cyc, hold;
    bit hs;
    push_r(a, len, size, burst, id);
    send_ar(a, len, size, burst, id);
    n = 0; cyc = 0; hold = 0;
    while (n <= len && cyc < 300) begin
      if (n == hold_beat && hold < 3) begin RREADY = 0; hold++; end
      else RREADY = !(stall && $urandom_range(0, 3) == 0);
      hs = RVALID && RREADY;
      tick();
      cyc++;
      if (hs) n++;
    end
    RREADY = 0;
    check("r_count", n, len + 1);
  endtask

  task automatic clear_got();
    got_r.delete(); got_rr.delete(); got_b.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    int len, size, burst, bad, r;

    // Reset with an active AW/W request: nothing may be accepted.
    AWVALID = 1; WVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WLAST = 1;
    repeat (2) begin
      tick();
      check("rst_ctl", {AWREADY, ARREADY, WREADY, BVALID, RVALID, RLAST}, 6'b110000);
      check("rst_data", {BRESP, RRESP, BID, RID, RDATA}, 44'h0);
    end
    AWVALID = 0; WVALID = 0; WLAST = 0; ARESET = 0;
    tick();
    chk_en = 1;

    // Fill the windows used by random traffic.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      do_write((k < 8) ? k * 64 : MEMB - 128 + (k - 8) * 64, 15, 2, 1, 4'(k), -1, 0);
    end

    // Second reset with AW/W active: word 0 must keep its value.
    AWVALID = 1; AWADDR = 0; AWLEN = 0; AWSIZE = 2; AWBURST = 1;
    WVALID = 1; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WLAST = 1; ARESET = 1;
    repeat (2) begin
      tick();
      check("rst2_ctl", {AWREADY, ARREADY, WREADY, BVALID, RVALID}, 5'b11000);
    end
    AWVALID = 0; WVALID = 0; WLAST = 0; ARESET = 0;
    tick();
    do_read(0, 0, 2, 1, 4'd1, 0, -1);

    // INCR write then read back.
    clear_got();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    do_write(32'h10, 3, 2, 1, 4'd5, -1, 0);
    check("incr_b", got_b[0], {2'b00, 4'd5});
    do_read(32'h10, 3, 2, 1, 4'd9, 0, -1);
    for (int i = 0; i < 4; i++) check("incr_rd", got_r[i], 32'hA0 + i);

    // WRAP write at 0x38, INCR read from 0x30.
    clear_got();
    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write(32'h38, 3, 2, 2, 4'd2, -1, 0);
    do_read(32'h30, 3, 2, 1, 4'd3, 0, -1);
    check("wrap0", got_r[0], 32'd3);
    check("wrap1", got_r[1], 32'd4);
    check("wrap2", got_r[2], 32'd1);
    check("wrap3", got_r[3], 32'd2);

    // Partial strobe write.
    clear_got();
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF;
    do_write(32'h40, 0, 2, 1, 4'd1, -1, 0);
    wd[0] = 32'h12345678; ws[0] = 4'h3;
    do_write(32'h40, 0, 2, 1, 4'd1, -1, 0);
    do_read(32'h40, 0, 2, 1, 4'd1, 0, -1);
    check("partial", got_r[0], 32'hFFFF5678);

    // Out-of-range read.
    clear_got();
    do_read(MEMB, 1, 2, 1, 4'd7, 0, -1);
    check("oor_resp0", {got_rr[0], got_r[0]}, {2'b10, 32'h0});
    check("oor_resp1", {got_rr[1], got_r[1]}, {2'b10, 32'h0});

    // Early WLAST on a 3-beat write: data still lands, BRESP is SLVERR.
    clear_got();
    for (int i = 0; i < 3; i++) begin wd[i] = 32'h5500 + i; ws[i] = 4'hF; end
    do_write(32'h80, 2, 2, 1, 4'd6, 1, 0);
    check("wlast_b", got_b[0], {2'b10, 4'd6});
    do_read(32'h80, 2, 2, 1, 4'd6, 0, -1);
    check("wlast_data", got_r[2], 32'h5502);

    // RREADY held low for 3 cycles on beat 1.
    do_read(32'h10, 3, 2, 1, 4'd4, 0, 1);

    // Reset during beat 1 of a 4-beat read.
    push_r(32'h10, 3, 2, 1, 4'd8);
    send_ar(32'h10, 3, 2, 1, 4'd8);
    RREADY = 1;
    tick();
    RREADY = 0; ARESET = 1;
    tick();
    ARESET = 0;
    check("mrst_rvalid", RVALID, 1'b0);
    check("mrst_arready", ARREADY, 1'b1);
    rexp_q.delete();
    clear_got();
    do_read(32'h10, 3, 2, 1, 4'd8, 0, -1);
    for (int i = 0; i < 4; i++) check("mrst_rd", got_r[i], 32'hA0 + i);

    // Random traffic.
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 19);
      if (r < 15)      a = $urandom_range(0, 252);
      else if (r < 18) a = MEMB - 32 + $urandom_range(0, 31);
      else             a = MEMB + $urandom_range(0, 255);
      len = $urandom_range(0, 15);
      r = $urandom_range(0, 5);
      size = (r == 0) ? 0 : (r == 1) ? 1 : (r == 5) ? 3 : 2;
      burst = $urandom_range(0, 2);
      if (burst == 2 && $urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 3))
          0: len = 1;
          1: len = 3;
          2: len = 7;
          default: len = 15;
        endcase
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 16; i++) begin
          wd[i] = $urandom;
          ws[i] = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
        end
        bad = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
        do_write(a, len, size, burst, 4'($urandom_range(0, 15)), bad, 1);
      end else begin
        do_read(a, len, size, burst, 4'($urandom_range(0, 15)), 1, -1);
      end
    end

    repeat (3) tick();
    check("r_drain", rexp_q.size(), 0);
    check("b_drain", bexp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
